// File: rtl/planificador_de_pisos_pkg.sv
// Shared definitions for the 4-floor elevator motion scheduler:
// FSM state codes, request button bit positions and estado field positions.
package planificador_de_pisos_pkg;

  // FSM state encodings
  localparam logic [2:0] REPOSO         = 3'd0;
  localparam logic [2:0] MOVIENDO       = 3'd1;
  localparam logic [2:0] PUERTAS_ABRIR  = 3'd2;
  localparam logic [2:0] PUERTAS_INICIO = 3'd3;
  localparam logic [2:0] PUERTAS_FIN    = 3'd4;

  // Bit positions inside the latched request vector
  localparam int BOT_P1_SUBE = 0;
  localparam int BOT_P2_BAJA = 1;
  localparam int BOT_P2_SUBE = 2;
  localparam int BOT_P3_BAJA = 3;
  localparam int BOT_P3_SUBE = 4;
  localparam int BOT_P4_BAJA = 5;
  localparam int BOT_CAB_P1  = 6;
  localparam int BOT_CAB_P2  = 7;
  localparam int BOT_CAB_P3  = 8;
  localparam int BOT_CAB_P4  = 9;

  // Field positions inside the estado word; the floor index is stored
  // bit-swapped (estado[0] carries the floor MSB)
  localparam int EST_PISO_MSB = 0;
  localparam int EST_PISO_LSB = 1;
  localparam int EST_DIR      = 2;
  localparam int EST_MOV      = 3;

  typedef logic [1:0] piso_t;

  // Packs moving flag, direction and floor index into the estado layout
  function automatic logic [3:0] armar_estado(input logic mov, input logic dir, input piso_t f);
    logic [3:0] e;
    e               = '0;
    e[EST_MOV]      = mov;
    e[EST_DIR]      = dir;
    e[EST_PISO_MSB] = f[1];
    e[EST_PISO_LSB] = f[0];
    return e;
  endfunction

endpackage

// File: rtl/planificador_de_pisos_detector_de_solicitudes.sv
// Combinational request decoder: given the latched buttons, a floor and a
// direction, reports whether there is a stop here, whether the opposite hall
// call is pending here, whether anything is pending above/below, and which
// request bits get cleared when this floor is served in this direction.
module detector_de_solicitudes
  import planificador_de_pisos_pkg::*;
(
  input  logic [9:0] solicitudes,
  input  piso_t      f,
  input  logic       dir,
  output logic       aqui,
  output logic       aqui_opuesto,
  output logic       arriba,
  output logic       abajo,
  output logic [9:0] mascara_limpiar
);

  logic [3:0] sube;
  logic [3:0] baja;
  logic [3:0] cabina;
  logic [3:0] pedido;
  logic [3:0] sobre;
  logic [3:0] bajo;

  // Regroup buttons per floor (missing P1-down / P4-up calls read as 0) and test relative to f
  always_comb begin
    sube   = {1'b0, solicitudes[BOT_P3_SUBE], solicitudes[BOT_P2_SUBE], solicitudes[BOT_P1_SUBE]};
    baja   = {solicitudes[BOT_P4_BAJA], solicitudes[BOT_P3_BAJA], solicitudes[BOT_P2_BAJA], 1'b0};
    cabina = {solicitudes[BOT_CAB_P4], solicitudes[BOT_CAB_P3],
              solicitudes[BOT_CAB_P2], solicitudes[BOT_CAB_P1]};
    pedido = sube | baja | cabina;
    sobre  = 4'b1110 << f;
    bajo   = 4'b0111 >> (~f);
    arriba = |(pedido & sobre);
    abajo  = |(pedido & bajo);
    aqui         = cabina[f] | (dir ? sube[f] : baja[f]);
    aqui_opuesto = dir ? baja[f] : sube[f];
  end

  // Serving floor f in direction dir clears its cabin button and its hall call in that direction
  always_comb begin
    mascara_limpiar = '0;
    case (f)
      2'd0: begin
        mascara_limpiar[BOT_CAB_P1] = 1'b1;
        if (dir) mascara_limpiar[BOT_P1_SUBE] = 1'b1;
      end
      2'd1: begin
        mascara_limpiar[BOT_CAB_P2] = 1'b1;
        if (dir) mascara_limpiar[BOT_P2_SUBE] = 1'b1;
        else     mascara_limpiar[BOT_P2_BAJA] = 1'b1;
      end
      2'd2: begin
        mascara_limpiar[BOT_CAB_P3] = 1'b1;
        if (dir) mascara_limpiar[BOT_P3_SUBE] = 1'b1;
        else     mascara_limpiar[BOT_P3_BAJA] = 1'b1;
      end
      default: begin
        mascara_limpiar[BOT_CAB_P4] = 1'b1;
        if (!dir) mascara_limpiar[BOT_P4_BAJA] = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/planificador_de_pisos.sv
// Motion scheduler for the 4-floor elevator. SCAN policy: keep the current
// direction while requests remain ahead, pace each floor with a travel
// counter, hand each stop to the door controller and clear served requests.
module planificador_de_pisos
  import planificador_de_pisos_pkg::*;
#(
  parameter int T_VIAJE  = 100,
  parameter int T_ESPERA = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] solicitudes,
  input  logic       puertas_trabajando,
  output logic [3:0] estado,
  output logic       orden_abrir,
  output logic [9:0] limpiar
);

  localparam logic [15:0] RECARGA_VIAJE = 16'(T_VIAJE - 1);
  localparam logic [15:0] FIN_ESPERA    = 16'(T_ESPERA - 1);

  logic [2:0]  estado_fsm;
  logic [2:0]  estado_sig;
  piso_t       piso;
  piso_t       piso_sig;
  piso_t       piso_eval;
  logic        dir;
  logic        dir_sig;
  logic [15:0] contador;
  logic [15:0] contador_sig;

  logic        llega;
  logic        en_extremo;
  logic        extremo_eval;
  logic        delante;
  logic        detras;

  logic        aqui;
  logic        aqui_opuesto;
  logic        arriba;
  logic        abajo;
  logic [9:0]  mascara;

  // On the counter-expiry cycle the stop test looks at the floor being arrived at
  always_comb begin
    llega      = (estado_fsm == MOVIENDO) && (contador == 16'd0);
    en_extremo = dir ? (piso == 2'd3) : (piso == 2'd0);
    piso_eval  = piso;
    if (llega && !en_extremo) begin
      piso_eval = dir ? (piso + 2'd1) : (piso - 2'd1);
    end
  end

  detector_de_solicitudes u_detector (
    .solicitudes     (solicitudes),
    .f               (piso_eval),
    .dir             (dir),
    .aqui            (aqui),
    .aqui_opuesto    (aqui_opuesto),
    .arriba          (arriba),
    .abajo           (abajo),
    .mascara_limpiar (mascara)
  );

  // Direction-relative view of the detector outputs
  always_comb begin
    extremo_eval = dir ? (piso_eval == 2'd3) : (piso_eval == 2'd0);
    delante      = dir ? arriba : abajo;
    detras       = dir ? abajo  : arriba;
  end

  // Next-state logic for the FSM, floor, direction and shared travel/wait counter
  always_comb begin
    estado_sig   = estado_fsm;
    piso_sig     = piso;
    dir_sig      = dir;
    contador_sig = contador;
    case (estado_fsm)
      REPOSO: begin
        if (aqui) begin
          estado_sig = PUERTAS_ABRIR;
        end else if (delante) begin
          estado_sig   = MOVIENDO;
          contador_sig = RECARGA_VIAJE;
        end else if (detras) begin
          dir_sig      = ~dir;
          estado_sig   = MOVIENDO;
          contador_sig = RECARGA_VIAJE;
        end else if (aqui_opuesto) begin
          dir_sig    = ~dir;
          estado_sig = PUERTAS_ABRIR;
        end
      end
      MOVIENDO: begin
        if (!llega) begin
          contador_sig = contador - 16'd1;
        end else begin
          piso_sig = piso_eval;
          if (aqui) begin
            estado_sig = PUERTAS_ABRIR;
          end else if (!delante && aqui_opuesto) begin
            dir_sig    = ~dir;
            estado_sig = PUERTAS_ABRIR;
          end else if (extremo_eval) begin
            estado_sig = REPOSO;
          end else begin
            contador_sig = RECARGA_VIAJE;
          end
        end
      end
      PUERTAS_ABRIR: begin
        estado_sig   = PUERTAS_INICIO;
        contador_sig = 16'd0;
      end
      PUERTAS_INICIO: begin
        if (puertas_trabajando) begin
          estado_sig = PUERTAS_FIN;
        end else if (contador == FIN_ESPERA) begin
          estado_sig = REPOSO;
        end else begin
          contador_sig = contador + 16'd1;
        end
      end
      PUERTAS_FIN: begin
        if (!puertas_trabajando) estado_sig = REPOSO;
      end
      default: begin
        estado_sig = REPOSO;
      end
    endcase
  end

  // State registers plus registered outputs. The clear mask is only driven once
  // the door controller has acknowledged (PUERTAS_FIN), so a stop that times
  // out in PUERTAS_INICIO leaves its request pending for a retry.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_fsm  <= REPOSO;
      piso        <= 2'd0;
      dir         <= 1'b1;
      contador    <= 16'd0;
      estado      <= 4'b0100;
      orden_abrir <= 1'b0;
      limpiar     <= '0;
    end else begin
      estado_fsm  <= estado_sig;
      piso        <= piso_sig;
      dir         <= dir_sig;
      contador    <= contador_sig;
      estado      <= armar_estado(estado_sig == MOVIENDO, dir_sig, piso_sig);
      orden_abrir <= (estado_sig == PUERTAS_ABRIR);
      limpiar     <= (estado_sig == PUERTAS_FIN) ? mascara : 10'd0;
    end
  end

endmodule

// File: tb/tb_planificador_de_pisos.sv
// Scoreboard bench for planificador_de_pisos with T_VIAJE=4, T_ESPERA=3.
// Stimulus pushes expected floor-change / door-open / clear events into a
// queue; a monitor pops and compares whenever the DUT produces one.
module tb_planificador_de_pisos;

  localparam logic [9:0] B_P3_BAJA = 10'b0000001000;
  localparam logic [9:0] B_P3_SUBE = 10'b0000010000;
  localparam logic [9:0] B_CAB_P1  = 10'b0001000000;
  localparam logic [9:0] B_CAB_P4  = 10'b1000000000;

  localparam int K_FLOOR = 0;
  localparam int K_OPEN  = 1;
  localparam int K_CLEAR = 2;

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] estado;
    logic [9:0] limpiar;
    logic [7:0] gap;
    logic [7:0] tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] solicitudes;
  logic       puertas_trabajando;
  logic [3:0] estado;
  logic       orden_abrir;
  logic [9:0] limpiar;

  exp_t       sb[$];
  int         vectors;
  int         errors;
  int         cyc;
  int         last_floor_cyc;
  int         last_open_cyc;
  int         busy_cnt;
  int         tag_next;
  logic       door_en;
  logic       mon_en;
  logic [1:0] prev_floor;
  logic [9:0] prev_limpiar;
  logic [9:0] pending;
  logic [9:0] drop;

  planificador_de_pisos #(
    .T_VIAJE  (4),
    .T_ESPERA (3)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .solicitudes        (solicitudes),
    .puertas_trabajando (puertas_trabajando),
    .estado             (estado),
    .orden_abrir        (orden_abrir),
    .limpiar            (limpiar)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  // Request latch and door controller model: presses latch, limpiar clears,
  // doors report busy for 5 cycles after each orden_abrir when enabled
  always @(negedge clk) begin
    solicitudes = (solicitudes & ~limpiar & ~drop) | pending;
    pending     = '0;
    drop        = '0;
    if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
    if (door_en && orden_abrir) busy_cnt = 5;
    puertas_trabajando = (busy_cnt != 0);
  end

  // Monitor: turn DUT outputs into events and score them against the queue
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mon_en && estado[1:0] != prev_floor) begin
      scoreEvent(K_FLOOR, cyc - last_floor_cyc);
      last_floor_cyc = cyc;
    end
    if (mon_en && orden_abrir) begin
      scoreEvent(K_OPEN, cyc - last_open_cyc);
      last_open_cyc = cyc;
    end
    if (mon_en && limpiar != 10'd0 && prev_limpiar == 10'd0) begin
      scoreEvent(K_CLEAR, 0);
    end
    prev_floor   = estado[1:0];
    prev_limpiar = limpiar;
  end

  // Safety net in case something stalls outside the bounded waits
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected to have finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic scoreEvent(input int kind, input int gap);
    exp_t e;
    logic ok;
    vectors = vectors + 1;
    if (sb.size() == 0) begin
      errors = errors + 1;
      $display("[TB] FAIL unexpected_event: got kind=%0d estado=%b limpiar=%b, expected no event",
               kind, estado, limpiar);
    end else begin
      e  = sb.pop_front();
      ok = (int'(e.kind) == kind) && (estado == e.estado) &&
           (kind != K_CLEAR || limpiar == e.limpiar) &&
           (e.gap == 8'd0 || gap == int'(e.gap));
      if (!ok) begin
        errors = errors + 1;
        $display("[TB] FAIL event%0d: got kind=%0d estado=%b limpiar=%b gap=%0d, expected kind=%0d estado=%b limpiar=%b gap=%0d",
                 e.tag, kind, estado, limpiar, gap, e.kind, e.estado, e.limpiar, e.gap);
      end
    end
  endtask

  task automatic expectEvent(input int kind, input logic [3:0] est, input logic [9:0] lim, input int gap);
    exp_t e;
    e.kind    = 2'(kind);
    e.estado  = est;
    e.limpiar = lim;
    e.gap     = 8'(gap);
    e.tag     = 8'(tag_next);
    tag_next  = tag_next + 1;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] mask);
    @(posedge clk);
    #1;
    pending = pending | mask;
  endtask

  task automatic applyDrop(input logic [9:0] mask);
    @(posedge clk);
    #1;
    drop = drop | mask;
  endtask

  task automatic applyReset();
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    drop  = '1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic waitDrain(input string name, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
    vectors = vectors + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("[TB] FAIL %s_drain: got %0d events still pending, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    reset              = 1'b1;
    solicitudes        = '0;
    puertas_trabajando = 1'b0;
    pending            = '0;
    drop               = '0;
    door_en            = 1'b1;
    mon_en             = 1'b0;
    vectors            = 0;
    errors             = 0;
    cyc                = 0;
    last_floor_cyc     = 0;
    last_open_cyc      = 0;
    busy_cnt           = 0;
    tag_next           = 0;
    prev_floor         = 2'b00;
    prev_limpiar       = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_estado", 16'(estado), 16'h0004);
    checkOutput("rst_orden", 16'(orden_abrir), 16'h0000);
    checkOutput("rst_limpiar", 16'(limpiar), 16'h0000);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Test 1: idle with no requests stays at P1, dir up, never opens
    mon_en = 1'b1;
    @(negedge clk);
    checkOutput("t1_idle_first", 16'(estado), 16'h0004);
    repeat (20) @(negedge clk);
    checkOutput("t1_idle_last", 16'(estado), 16'h0004);

    // Test 2: cabin P4 from P1, one floor every 4 cycles, single open at P4
    expectEvent(K_FLOOR, 4'b1110, '0, 0);
    expectEvent(K_FLOOR, 4'b1101, '0, 4);
    expectEvent(K_FLOOR, 4'b0111, '0, 4);
    expectEvent(K_OPEN,  4'b0111, '0, 0);
    expectEvent(K_CLEAR, 4'b0111, 10'b1000000000, 0);
    applyStimulus(B_CAB_P4);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t2_moving", 16'(estado), 16'h000C);
    waitDrain("t2", 60);
    repeat (10) @(negedge clk);
    checkOutput("t2_idle", 16'(estado), 16'h0007);
    checkOutput("t2_served", 16'(solicitudes), 16'h0000);

    // Test 3: cabin P4 + P3-down: pass P3 going up, stop P4, come back to P3
    applyReset();
    expectEvent(K_FLOOR, 4'b1110, '0, 0);
    expectEvent(K_FLOOR, 4'b1101, '0, 4);
    expectEvent(K_FLOOR, 4'b0111, '0, 4);
    expectEvent(K_OPEN,  4'b0111, '0, 0);
    expectEvent(K_CLEAR, 4'b0111, 10'b1000000000, 0);
    expectEvent(K_FLOOR, 4'b0001, '0, 0);
    expectEvent(K_OPEN,  4'b0001, '0, 0);
    expectEvent(K_CLEAR, 4'b0001, 10'b0100001000, 0);
    applyStimulus(B_CAB_P4 | B_P3_BAJA);
    waitDrain("t3", 100);
    repeat (10) @(negedge clk);
    checkOutput("t3_idle", 16'(estado), 16'h0001);

    // Test 4: P3-up ahead, cabin P1 added while passing P2: serve P3 then reverse
    applyReset();
    expectEvent(K_FLOOR, 4'b1110, '0, 0);
    expectEvent(K_FLOOR, 4'b0101, '0, 4);
    expectEvent(K_OPEN,  4'b0101, '0, 0);
    expectEvent(K_CLEAR, 4'b0101, 10'b0100010000, 0);
    expectEvent(K_FLOOR, 4'b1010, '0, 0);
    expectEvent(K_FLOOR, 4'b0000, '0, 4);
    expectEvent(K_OPEN,  4'b0000, '0, 0);
    expectEvent(K_CLEAR, 4'b0000, 10'b0001000000, 0);
    applyStimulus(B_P3_SUBE);
    begin : wait_p2
      int k;
      for (k = 0; k < 40; k++) begin
        @(negedge clk);
        if (estado == 4'b1110) break;
      end
      checkOutput("t4_reach_p2", 16'(k < 40), 16'h0001);
    end
    applyStimulus(B_CAB_P1);
    waitDrain("t4", 100);
    repeat (10) @(negedge clk);
    checkOutput("t4_idle", 16'(estado), 16'h0000);
    checkOutput("t4_served", 16'(solicitudes), 16'h0000);

    // Test 5: doors never acknowledge: 3-cycle timeout, no clear, retried
    applyReset();
    door_en = 1'b0;
    expectEvent(K_OPEN, 4'b0100, '0, 0);
    expectEvent(K_OPEN, 4'b0100, '0, 5);
    applyStimulus(B_CAB_P1);
    waitDrain("t5", 40);
    checkOutput("t5_still_pending", 16'(solicitudes), 16'(B_CAB_P1));
    applyDrop(B_CAB_P1);
    repeat (10) @(negedge clk);
    checkOutput("t5_idle", 16'(estado), 16'h0004);
    door_en = 1'b1;

    // Test 6: reset while travelling returns to the reset state next cycle
    applyReset();
    mon_en = 1'b0;
    applyStimulus(B_CAB_P4);
    repeat (6) @(negedge clk);
    checkOutput("t6_moving", 16'(estado[3]), 16'h0001);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drop  = '1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t6_estado", 16'(estado), 16'h0004);
    checkOutput("t6_orden", 16'(orden_abrir), 16'h0000);
    checkOutput("t6_limpiar", 16'(limpiar), 16'h0000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
